// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } div_state_e;

    function automatic logic [31:0] half_div(input logic [31:0] n);
        return n >> 1;
    endfunction

    function automatic logic div_legal(input logic [31:0] n);
        return n >= MIN_DIV;
    endfunction

endpackage

// File: rtl/clk_div_if.sv
// Control/status bundle of the programmable clock divider.
interface clk_div_if #(
    parameter int unsigned W = 8
);
    logic         en;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         clk_out;
    logic [W-1:0] div_active;
    logic         running;
    logic         period_tick;
    logic         div_err;

    modport master (
        output en, div_in, div_load,
        input  clk_out, div_active, running, period_tick, div_err
    );

    modport slave (
        input  en, div_in, div_load,
        output clk_out, div_active, running, period_tick, div_err
    );
endinterface

// File: rtl/clk_div_negret.sv
// Falling-edge retime of the divider high phase; isolated so timing constraints can target it.
module clk_div_negret (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    always_ff @(negedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end
endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even divisors.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned DEFAULT_DIV = 15
) (
    input logic       clk,
    input logic       rst,
    clk_div_if.slave  bus
);
    div_state_e   state;
    logic [W-1:0] posc;
    logic [W-1:0] pend;
    logic [W-1:0] div_active;
    logic         pos_hi;
    logic         neg_hi;
    logic         pend_vld;
    logic         period_tick;
    logic         div_err;

    logic         load_ok;
    logic         at_boundary;
    logic         apply_now;
    logic [W-1:0] div_next;
    logic [W-1:0] posc_inc;
    logic [W-1:0] half_cur;

    always_comb begin
        load_ok     = bus.div_load && div_legal(32'(bus.div_in));
        at_boundary = (state == ST_RUN) && (posc == div_active - W'(1));
        apply_now   = at_boundary || ((state == ST_IDLE) && bus.en);
        // A legal load landing on the apply edge wins over anything pending.
        div_next    = load_ok ? bus.div_in : (pend_vld ? pend : div_active);
        posc_inc    = posc + W'(1);
        half_cur    = W'(half_div(32'(div_active)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            posc        <= '0;
            pos_hi      <= 1'b0;
            pend        <= '0;
            pend_vld    <= 1'b0;
            div_active  <= W'(DEFAULT_DIV);
            period_tick <= 1'b0;
            div_err     <= 1'b0;
        end else begin
            period_tick <= 1'b0;
            div_err     <= bus.div_load && !div_legal(32'(bus.div_in));
            if (apply_now) begin
                div_active <= div_next;
                pend_vld   <= 1'b0;
                posc       <= '0;
                if (bus.en) begin
                    state       <= ST_RUN;
                    pos_hi      <= 1'b1;
                    period_tick <= 1'b1;
                end else begin
                    state  <= ST_IDLE;
                    pos_hi <= 1'b0;
                end
            end else begin
                if (load_ok) begin
                    pend     <= bus.div_in;
                    pend_vld <= 1'b1;
                end
                if (state == ST_RUN) begin
                    posc   <= posc_inc;
                    pos_hi <= (posc_inc < half_cur);
                end
            end
        end
    end

    clk_div_negret u_negret (
        .clk (clk),
        .rst (rst),
        .d   (pos_hi),
        .q   (neg_hi)
    );

    // Odd divisors stretch the high phase by the half cycle held in neg_hi.
    assign bus.clk_out     = div_active[0] ? (pos_hi | neg_hi) : pos_hi;
    assign bus.div_active  = div_active;
    assign bus.running     = (state == ST_RUN);
    assign bus.period_tick = period_tick;
    assign bus.div_err     = div_err;

endmodule
